// File: rtl/spi_cmd_unpacker.sv
// Unpacks 32-bit host command words from a standard-read FIFO into 16-bit SPI
// commands (low half first), substituting an idle filler and counting underruns.
module spi_cmd_unpacker #(
    parameter int unsigned CMDS_PER_FRAME = 35,
    parameter logic [15:0] IDLE_CMD       = 16'hFF00
) (
    input  logic        spi_clk,
    input  logic        fifo_reset,
    input  logic [31:0] fifo_dout,
    input  logic        fifo_empty,
    output logic        fifo_rden,
    input  logic        frame_start,
    input  logic        cmd_req,
    output logic [15:0] cmd_data,
    output logic        cmd_valid,
    output logic [5:0]  cmd_slot,
    output logic        underrun,
    output logic [15:0] underrun_count
);

    typedef enum logic [1:0] {FETCH, WAIT, HAVE_LO, HAVE_HI} state_t;

    localparam logic [5:0] LAST_SLOT = 6'(CMDS_PER_FRAME - 1);

    state_t      r_state;
    logic [31:0] r_word;
    logic [15:0] r_cmd_data;
    logic        r_cmd_valid;
    logic [5:0]  r_slot;
    logic        r_underrun;
    logic [15:0] r_underrun_count;
    logic        w_rden;

    // Reads are issued from FETCH, or on the request that consumes the high half.
    always_comb begin
        w_rden = 1'b0;
        if (!fifo_reset && !fifo_empty)
            w_rden = (r_state == FETCH) || (r_state == HAVE_HI && cmd_req);
    end

    always_ff @(posedge spi_clk or posedge fifo_reset) begin
        if (fifo_reset) begin
            r_state          <= FETCH;
            r_word           <= '0;
            r_cmd_data       <= IDLE_CMD;
            r_cmd_valid      <= 1'b0;
            r_slot           <= '0;
            r_underrun       <= 1'b0;
            r_underrun_count <= '0;
        end else begin
            case (r_state)
                FETCH: begin
                    if (!fifo_empty)
                        r_state <= WAIT;
                end
                WAIT: begin
                    r_word      <= fifo_dout;
                    r_cmd_data  <= fifo_dout[15:0];
                    r_cmd_valid <= 1'b1;
                    r_state     <= HAVE_LO;
                end
                HAVE_LO: begin
                    if (cmd_req) begin
                        r_cmd_data <= r_word[31:16];
                        r_state    <= HAVE_HI;
                    end
                end
                HAVE_HI: begin
                    if (cmd_req) begin
                        r_cmd_data  <= IDLE_CMD;
                        r_cmd_valid <= 1'b0;
                        r_state     <= fifo_empty ? FETCH : WAIT;
                    end
                end
                default: r_state <= FETCH;
            endcase

            if (cmd_req && !r_cmd_valid) begin
                r_underrun <= 1'b1;
                if (r_underrun_count != '1)
                    r_underrun_count <= r_underrun_count + 16'd1;
            end

            // A request coincident with frame_start occupies slot 0.
            if (frame_start)
                r_slot <= cmd_req ? 6'd1 : '0;
            else if (cmd_req)
                r_slot <= (r_slot == LAST_SLOT) ? '0 : r_slot + 6'd1;
        end
    end

    assign fifo_rden      = w_rden;
    assign cmd_data       = r_cmd_data;
    assign cmd_valid      = r_cmd_valid;
    assign cmd_slot       = r_slot;
    assign underrun       = r_underrun;
    assign underrun_count = r_underrun_count;

endmodule

// File: tb/tb_spi_cmd_unpacker.sv
// Self-checking bench for spi_cmd_unpacker: directed cases plus randomized
// traffic checked against a queue-of-halves reference model.
module tb_spi_cmd_unpacker;

    localparam int unsigned N = 35;

    logic        spi_clk = 1'b0;
    logic        fifo_reset;
    logic [31:0] fifo_dout;
    logic        fifo_empty;
    logic        fifo_rden;
    logic        frame_start;
    logic        cmd_req;
    logic [15:0] cmd_data;
    logic        cmd_valid;
    logic [5:0]  cmd_slot;
    logic        underrun;
    logic [15:0] underrun_count;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [31:0] fq[$];
    logic [15:0] hq[$];
    int unsigned m_slot;
    logic [15:0] exp_cnt;
    logic        exp_und;
    int unsigned rden_hi;
    logic        last_rden;

    spi_cmd_unpacker #(.CMDS_PER_FRAME(N), .IDLE_CMD(16'hFF00)) dut (
        .spi_clk        (spi_clk),
        .fifo_reset     (fifo_reset),
        .fifo_dout      (fifo_dout),
        .fifo_empty     (fifo_empty),
        .fifo_rden      (fifo_rden),
        .frame_start    (frame_start),
        .cmd_req        (cmd_req),
        .cmd_data       (cmd_data),
        .cmd_valid      (cmd_valid),
        .cmd_slot       (cmd_slot),
        .underrun       (underrun),
        .underrun_count (underrun_count)
    );

    always #5 spi_clk = ~spi_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] w);
        fq.push_back(w);
        hq.push_back(w[15:0]);
        hq.push_back(w[31:16]);
        fifo_empty = 1'b0;
    endtask

    // One clock: entered and left at posedge+1; FIFO model serves reads.
    task automatic tick(input bit req, input bit fs);
        cmd_req     = req;
        frame_start = fs;
        #7;
        last_rden = fifo_rden;
        if (fifo_rden) begin
            rden_hi++;
            chk("rden_while_empty", {31'd0, fifo_empty}, 32'd0);
        end
        @(posedge spi_clk);
        #1;
        if (last_rden && fq.size() > 0)
            fifo_dout = fq.pop_front();
        fifo_empty  = (fq.size() == 0);
        cmd_req     = 1'b0;
        frame_start = 1'b0;
        if (fs)
            m_slot = req ? 1 : 0;
        else if (req)
            m_slot = (m_slot + 1) % N;
    endtask

    task automatic req_model(input bit fs);
        if (hq.size() > 0) begin
            chk("cmd_valid", {31'd0, cmd_valid}, 32'd1);
            chk("cmd_data", {16'd0, cmd_data}, {16'd0, hq.pop_front()});
        end else begin
            chk("cmd_valid", {31'd0, cmd_valid}, 32'd0);
            chk("cmd_data", {16'd0, cmd_data}, 32'h0000_FF00);
            if (exp_cnt != 16'hFFFF)
                exp_cnt = exp_cnt + 16'd1;
            exp_und = 1'b1;
        end
        chk("cmd_slot", {26'd0, cmd_slot}, m_slot);
        tick(1'b1, fs);
        chk("underrun", {31'd0, underrun}, {31'd0, exp_und});
        chk("underrun_count", {16'd0, underrun_count}, {16'd0, exp_cnt});
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++)
            tick(1'b0, 1'b0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_data"},  {16'd0, cmd_data}, 32'h0000_FF00);
        chk({tag, "_valid"}, {31'd0, cmd_valid}, 32'd0);
        chk({tag, "_slot"},  {26'd0, cmd_slot}, 32'd0);
        chk({tag, "_und"},   {31'd0, underrun}, 32'd0);
        chk({tag, "_cnt"},   {16'd0, underrun_count}, 32'd0);
        chk({tag, "_rden"},  {31'd0, fifo_rden}, 32'd0);
    endtask

    initial begin
        int unsigned next_req;
        bit r;
        bit fs;
        int unsigned push_pct;

        fifo_reset  = 1'b1;
        cmd_req     = 1'b0;
        frame_start = 1'b0;
        fifo_empty  = 1'b1;
        fifo_dout   = '0;
        exp_cnt     = '0;
        exp_und     = 1'b0;
        m_slot      = 0;
        rden_hi     = 0;
        last_rden   = 1'b0;

        #12;
        chk_reset_outputs("por");
        #10;
        fifo_reset = 1'b0;
        @(posedge spi_clk);
        #1;

        // Starved after reset: three fillers, no reads.
        for (int i = 0; i < 3; i++) begin
            req_model(1'b0);
            idle(3);
        end
        chk("t1_count", {16'd0, underrun_count}, 32'd3);
        chk("t1_rden_count", rden_hi, 32'd0);

        // Two words, request every 8 cycles, then one filler.
        push(32'hBBBB_AAAA);
        push(32'hDDDD_CCCC);
        idle(3);
        for (int i = 0; i < 5; i++) begin
            req_model(1'b0);
            idle(7);
        end
        chk("t2_count", {16'd0, underrun_count}, 32'd4);

        // Word arrives while starved; request lands during the read latency.
        push(32'h0002_0001);
        tick(1'b0, 1'b0);
        chk("t3_rden", {31'd0, last_rden}, 32'd1);
        chk("t3_wait_valid", {31'd0, cmd_valid}, 32'd0);
        chk("t3_wait_data", {16'd0, cmd_data}, 32'h0000_FF00);
        tick(1'b1, 1'b0);
        exp_cnt = exp_cnt + 16'd1;
        exp_und = 1'b1;
        chk("t3_count", {16'd0, underrun_count}, {16'd0, exp_cnt});
        idle(3);
        req_model(1'b0);
        idle(3);
        req_model(1'b0);
        idle(3);

        // Slot counter wrap and coincident frame_start.
        tick(1'b0, 1'b1);
        chk("t4_slot_fs", {26'd0, cmd_slot}, 32'd0);
        for (int unsigned k = 1; k <= 36; k++) begin
            req_model(1'b0);
            if (k == 34) chk("t4_slot_34", {26'd0, cmd_slot}, 32'd34);
            if (k == 35) chk("t4_slot_wrap", {26'd0, cmd_slot}, 32'd0);
            if (k == 36) chk("t4_slot_after", {26'd0, cmd_slot}, 32'd1);
            idle(3);
        end
        req_model(1'b1);
        chk("t4_slot_coinc", {26'd0, cmd_slot}, 32'd1);
        idle(3);

        // Async reset while the high half is pending.
        push(32'h2222_1111);
        idle(3);
        req_model(1'b0);
        tick(1'b0, 1'b0);
        fq.push_back(32'h9999_8888);
        fifo_empty = 1'b0;
        #3;
        fifo_reset = 1'b1;
        #1;
        chk_reset_outputs("arst");
        fq.delete();
        hq.delete();
        fifo_empty = 1'b1;
        exp_cnt    = '0;
        exp_und    = 1'b0;
        m_slot     = 0;
        #2;
        fifo_reset = 1'b0;
        @(posedge spi_clk);
        #1;
        chk("arst_post_valid", {31'd0, cmd_valid}, 32'd0);
        push(32'h6666_5555);
        idle(3);
        chk("arst_first_cmd", {16'd0, cmd_data}, 32'h0000_5555);
        req_model(1'b0);
        idle(3);
        req_model(1'b0);
        idle(3);

        // Randomized traffic against the queue model.
        next_req = 4;
        for (int unsigned cyc = 0; cyc < 4000; cyc++) begin
            push_pct = (cyc < 2000) ? 20 : 6;
            r  = (cyc == next_req);
            fs = ($urandom_range(0, 39) == 0);
            if (!r && (next_req - cyc) >= 3 && fq.size() < 16 && $urandom_range(0, 99) < push_pct)
                push($urandom);
            if (r) begin
                req_model(fs);
                next_req = cyc + $urandom_range(4, 12);
            end else begin
                tick(1'b0, fs);
            end
        end
        idle(4);
        for (int i = 0; i < 40 && hq.size() > 0; i++) begin
            req_model(1'b0);
            idle(3);
        end
        chk("drain_empty", hq.size(), 32'd0);

        // Saturation of the underrun counter.
        force dut.r_underrun_count = 16'hFFFD;
        tick(1'b0, 1'b0);
        release dut.r_underrun_count;
        tick(1'b0, 1'b0);
        chk("sat_preload", {16'd0, underrun_count}, 32'h0000_FFFD);
        exp_cnt = 16'hFFFD;
        for (int i = 0; i < 3; i++) begin
            req_model(1'b0);
            idle(3);
        end
        chk("sat_hold", {16'd0, underrun_count}, 32'h0000_FFFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
